// File: rtl/arrayed_sig_bank.sv
// arrayed_sig_bank: DEPTH x WIDTH array with load/rotate/addressed write, registered read, write counter; ARRAY_ADDR_SWAP_EN mirrors addressed indices
module arrayed_sig_bank #(
    parameter int WIDTH  = 2,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_all,
    input  logic [DEPTH*WIDTH-1:0]   data_all,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rot_en,
    input  logic                     rd_en,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic                     wr_drop,
    output logic                     addr_err,
    output logic [CNT_W-1:0]         wr_count,
    output logic [DEPTH*WIDTH-1:0]   out
);
    localparam logic [ADDR_W:0]   LIM  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH-1);
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];
    logic [WIDTH-1:0]  rd_data_q, rd_data_d, rd_word;
    logic              rd_valid_q, wr_drop_q, wr_drop_d, addr_err_q, addr_err_d;
    logic [CNT_W-1:0]  wr_count_q, wr_count_d;
    logic [ADDR_W-1:0] wr_idx, rd_idx;
    logic              wr_ok, rd_ok, wr_apply;
`ifdef ARRAY_ADDR_SWAP_EN
    assign wr_idx = LAST - wr_addr;
    assign rd_idx = LAST - rd_addr;
`else
    assign wr_idx = wr_addr;
    assign rd_idx = rd_addr;
`endif
    // range check always uses the raw address, independent of index mapping
    assign wr_ok    = {1'b0, wr_addr} < LIM;
    assign rd_ok    = {1'b0, rd_addr} < LIM;
    assign wr_apply = wr_en && !load_all && !rot_en;
    always_comb begin
        mem_d   = mem_q;
        rd_word = '0;
        out     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = load_all ? data_all[(DEPTH-1-i)*WIDTH +: WIDTH]
                     : rot_en ? mem_q[(i+1) % DEPTH]
                     : (wr_apply && wr_ok && wr_idx == ADDR_W'(i)) ? wr_data : mem_q[i];
            if (rd_ok && rd_idx == ADDR_W'(i)) rd_word = mem_q[i];
            out[(DEPTH-1-i)*WIDTH +: WIDTH] = mem_q[i];
        end
        rd_data_d  = rd_en ? rd_word : rd_data_q;
        wr_count_d = wr_count_q + CNT_W'(load_all || (wr_apply && wr_ok));
        wr_drop_d  = wr_en && (load_all || rot_en);
        addr_err_d = (wr_apply && !wr_ok) || (rd_en && !rd_ok);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q      <= '{default: '0};
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            wr_drop_q  <= 1'b0;
            addr_err_q <= 1'b0;
            wr_count_q <= '0;
        end else begin
            mem_q      <= mem_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_en;
            wr_drop_q  <= wr_drop_d;
            addr_err_q <= addr_err_d;
            wr_count_q <= wr_count_d;
        end
    end
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign wr_drop  = wr_drop_q;
    assign addr_err = addr_err_q;
    assign wr_count = wr_count_q;
endmodule

// File: tb/tb_arrayed_sig_bank.sv
// tb_arrayed_sig_bank: scoreboard bench for arrayed_sig_bank (DEPTH=4 main instance, DEPTH=3 range instance)
module tb_arrayed_sig_bank;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic load_all = 0, wr_en = 0, rot_en = 0, rd_en = 0;
    logic [7:0] data_all = '0;
    logic [1:0] wr_addr = '0, wr_data = '0, rd_addr = '0;
    logic [1:0] rd_data;
    logic rd_valid, wr_drop, addr_err;
    logic [7:0] wr_count, out;
    logic b_load_all = 0, b_wr_en = 0, b_rot_en = 0, b_rd_en = 0;
    logic [5:0] b_data_all = '0;
    logic [1:0] b_wr_addr = '0, b_wr_data = '0, b_rd_addr = '0;
    logic [1:0] b_rd_data;
    logic b_rd_valid, b_wr_drop, b_addr_err;
    logic [7:0] b_wr_count;
    logic [5:0] b_out;
    int errors = 0;
    int checks = 0;
    logic [1:0] sb_a[$];
    logic [1:0] sb_b[$];

    arrayed_sig_bank u_a (
        .clk(clk), .rst(rst), .load_all(load_all), .data_all(data_all), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .rot_en(rot_en), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .wr_drop(wr_drop), .addr_err(addr_err),
        .wr_count(wr_count), .out(out)
    );
    arrayed_sig_bank #(.WIDTH(2), .DEPTH(3), .ADDR_W(2), .CNT_W(8)) u_b (
        .clk(clk), .rst(rst), .load_all(b_load_all), .data_all(b_data_all), .wr_en(b_wr_en),
        .wr_addr(b_wr_addr), .wr_data(b_wr_data), .rot_en(b_rot_en), .rd_en(b_rd_en), .rd_addr(b_rd_addr),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid), .wr_drop(b_wr_drop), .addr_err(b_addr_err),
        .wr_count(b_wr_count), .out(b_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        logic [1:0] e;
        if (rd_valid) begin
            checks++;
            if (sb_a.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected_a: rd_valid=1 with no read pending");
            end else begin
                e = sb_a.pop_front();
                if (rd_data !== e) begin
                    errors++;
                    $display("FAIL rd_data_a: got %b expected %b", rd_data, e);
                end
            end
        end
        if (b_rd_valid) begin
            checks++;
            if (sb_b.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected_b: rd_valid=1 with no read pending");
            end else begin
                e = sb_b.pop_front();
                if (b_rd_data !== e) begin
                    errors++;
                    $display("FAIL rd_data_b: got %b expected %b", b_rd_data, e);
                end
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        checks++;
        if (out !== 8'h00 || wr_count !== 8'h00 || rd_data !== 2'b00) begin
            errors++;
            $display("FAIL reset_state: out=%h cnt=%0d rd_data=%b expected 00/0/00", out, wr_count, rd_data);
        end
        checks++;
        if ({rd_valid, wr_drop, addr_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_pulses: got %b expected 000", {rd_valid, wr_drop, addr_err});
        end
        checks++;
        if (b_out !== 6'h00 || b_wr_count !== 8'h00) begin
            errors++;
            $display("FAIL reset_b: out=%h cnt=%0d expected 00/0", b_out, b_wr_count);
        end
    endtask

    task automatic test_load_then_reset();
        data_all = 8'b00011011; load_all = 1;
        cyc();
        load_all = 0;
        checks++;
        if (out !== 8'h1B || wr_count !== 8'd1) begin
            errors++;
            $display("FAIL load_all: out=%h cnt=%0d expected 1b/1", out, wr_count);
        end
        rst = 1; rd_en = 1; rd_addr = 2'd0;
        cyc();
        rst = 0; rd_en = 0;
        checks++;
        if (out !== 8'h00 || wr_count !== 8'd0 || {rd_valid, wr_drop, addr_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_after_load: out=%h cnt=%0d pulses=%b expected 00/0/000",
                     out, wr_count, {rd_valid, wr_drop, addr_err});
        end
    endtask

    task automatic test_rw_same_cycle();
        wr_en = 1; wr_addr = 2'd2; wr_data = 2'b11; rd_en = 1; rd_addr = 2'd2;
        sb_a.push_back(2'b00);
        cyc();
        wr_en = 0;
        sb_a.push_back(2'b11);
        cyc();
        rd_en = 0;
        checks++;
        if (out !== 8'b00001100 || wr_count !== 8'd1) begin
            errors++;
            $display("FAIL rw_same_out: out=%b cnt=%0d expected 00001100/1", out, wr_count);
        end
        cyc();
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 2'b11) begin
            errors++;
            $display("FAIL rd_hold: valid=%b data=%b expected 0/11", rd_valid, rd_data);
        end
    endtask

    task automatic test_rotate();
        data_all = 8'h1B; load_all = 1;
        cyc();
        load_all = 0; rot_en = 1;
        cyc();
        checks++;
        if (out !== 8'b01101100) begin
            errors++;
            $display("FAIL rotate_1: out=%b expected 01101100", out);
        end
        repeat (3) cyc();
        rot_en = 0;
        checks++;
        if (out !== 8'h1B || wr_count !== 8'd2) begin
            errors++;
            $display("FAIL rotate_4: out=%h cnt=%0d expected 1b/2", out, wr_count);
        end
    endtask

    task automatic test_overridden_write();
        rot_en = 1; wr_en = 1; wr_addr = 2'd0; wr_data = 2'b10;
        cyc();
        rot_en = 0; wr_en = 0;
        checks++;
        if (out !== 8'b01101100 || wr_count !== 8'd2 || wr_drop !== 1'b1 || addr_err !== 1'b0) begin
            errors++;
            $display("FAIL rot_drop: out=%b cnt=%0d drop=%b aerr=%b expected 01101100/2/1/0",
                     out, wr_count, wr_drop, addr_err);
        end
        cyc();
        checks++;
        if (wr_drop !== 1'b0) begin
            errors++;
            $display("FAIL drop_pulse: drop=%b expected 0", wr_drop);
        end
        load_all = 1; data_all = 8'hFF; wr_en = 1; wr_addr = 2'd1; wr_data = 2'b00;
        cyc();
        load_all = 0; wr_en = 0;
        checks++;
        if (out !== 8'hFF || wr_count !== 8'd3 || wr_drop !== 1'b1) begin
            errors++;
            $display("FAIL load_drop: out=%h cnt=%0d drop=%b expected ff/3/1", out, wr_count, wr_drop);
        end
    endtask

    task automatic test_addr_range();
        b_data_all = 6'b011011; b_load_all = 1;
        cyc();
        b_load_all = 0; b_wr_en = 1; b_wr_addr = 2'd3; b_wr_data = 2'b00;
        cyc();
        b_wr_en = 0;
        checks++;
        if (b_out !== 6'b011011 || b_wr_count !== 8'd1 || b_addr_err !== 1'b1) begin
            errors++;
            $display("FAIL wr_oor: out=%b cnt=%0d aerr=%b expected 011011/1/1", b_out, b_wr_count, b_addr_err);
        end
        b_rd_en = 1; b_rd_addr = 2'd1;
        sb_b.push_back(2'b10);
        cyc();
        checks++;
        if (b_addr_err !== 1'b0) begin
            errors++;
            $display("FAIL rd_inrange_aerr: aerr=%b expected 0", b_addr_err);
        end
        b_rd_addr = 2'd3;
        sb_b.push_back(2'b00);
        cyc();
        b_rd_en = 0;
        checks++;
        if (b_addr_err !== 1'b1 || b_rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL rd_oor: aerr=%b valid=%b expected 1/1", b_addr_err, b_rd_valid);
        end
    endtask

    task automatic test_swap_and_wrap();
        logic [7:0] e1, e2;
`ifdef ARRAY_ADDR_SWAP_EN
        e1 = 8'b00000001; e2 = 8'b00001001;
`else
        e1 = 8'b01000000; e2 = 8'b01100000;
`endif
        rst = 1;
        cyc();
        rst = 0; wr_en = 1; wr_addr = 2'd0; wr_data = 2'b01;
        cyc();
        wr_en = 0;
        checks++;
        if (out !== e1 || wr_count !== 8'd1) begin
            errors++;
            $display("FAIL addr_map: out=%b cnt=%0d expected %b/1", out, wr_count, e1);
        end
        rd_en = 1; rd_addr = 2'd0; wr_en = 1; wr_addr = 2'd1; wr_data = 2'b10;
        sb_a.push_back(2'b01);
        cyc();
        rd_en = 0;
        repeat (253) cyc();
        checks++;
        if (wr_count !== 8'd255 || out !== e2) begin
            errors++;
            $display("FAIL count_255: cnt=%0d out=%b expected 255/%b", wr_count, out, e2);
        end
        cyc();
        wr_en = 0;
        checks++;
        if (wr_count !== 8'd0) begin
            errors++;
            $display("FAIL count_wrap: cnt=%0d expected 0", wr_count);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 0;
        test_reset();
        test_load_then_reset();
        test_rw_same_cycle();
        test_rotate();
        test_overridden_write();
        test_addr_range();
        test_swap_and_wrap();
        cyc();
        checks++;
        if (sb_a.size() != 0 || sb_b.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: pending a=%0d b=%0d expected 0/0", sb_a.size(), sb_b.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/arrayed_sig_bank.md
Name: arrayed_sig_bank

Overview:
Parametrised successor to the fixed 4x2-bit arrayed sink register: an array of DEPTH entries, each WIDTH bits wide, with three write modes: parallel load of all entries, single addressed write, and circular rotate. It also has a registered addressed read port and an accepted-write counter. The block sits in the ivl_ttb test set as a generic arrayed-signal sink. The full array is also exposed as one flat concatenated output.

Parameters:
WIDTH, 2, bits per entry (>=1)
DEPTH, 4, number of entries (>=2, need not be a power of 2)
ADDR_W, 2, address width; must satisfy 2**ADDR_W >= DEPTH
CNT_W, 8, width of accepted-write counter

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  reset, synchronous, active-high
load_all  in  1  parallel load of every entry from data_all
data_all  in  DEPTH*WIDTH  parallel load data; entry i = data_all[(DEPTH-1-i)*WIDTH +: WIDTH]
wr_en  in  1  single addressed write request
wr_addr  in  ADDR_W  write index
wr_data  in  WIDTH  write data
rot_en  in  1  rotate array by one entry
rd_en  in  1  read request
rd_addr  in  ADDR_W  read index
rd_data  out  WIDTH  registered read data
rd_valid  out  1  one-cycle pulse, rd_data valid
wr_drop  out  1  one-cycle pulse, wr_en request not applied
addr_err  out  1  one-cycle pulse, out-of-range wr or rd address
wr_count  out  CNT_W  count of accepted writes, wraps mod 2**CNT_W
out  out  DEPTH*WIDTH  {mem[0], mem[1], ..., mem[DEPTH-1]}, mem[0] in MSBs

Behaviour:
- Reset is synchronous and active-high on clk. On reset: all mem entries = 0; rd_data = 0; rd_valid = 0; wr_drop = 0; addr_err = 0; wr_count = 0. Reset overrides every other input in that cycle. A read in flight during reset is discarded, and no rd_valid follows.
- Write priority per cycle: rst > load_all > rot_en > wr_en.
  - load_all: every entry is loaded from data_all. Counts as one accepted write (wr_count += 1).
  - rot_en: mem[i] <= mem[i+1] for i < DEPTH-1, and mem[DEPTH-1] <= mem[0]. Does not change wr_count.
  - wr_en alone with wr_addr < DEPTH: mem[wr_addr] <= wr_data, wr_count += 1.
- wr_drop: pulses for one cycle, one cycle later, when wr_en = 1 but the write was overridden by load_all or rot_en. addr_err does not assert in that case.
- Out-of-range address (>= DEPTH), write: the write is ignored, wr_count is unchanged, and addr_err pulses one cycle later.
- Out-of-range address, read: rd_data = 0, rd_valid still pulses, and addr_err pulses.
- Read port: 1-cycle latency. rd_en in cycle N gives rd_data and rd_valid in cycle N+1.
  - The read samples the pre-update array, so a read of an address written in the same cycle returns the old value.
  - rd_data holds its last value while rd_valid = 0.
- out: combinational view of the current registered array, so it reflects a write one cycle after the request.
- wr_count wraps from 2**CNT_W-1 to 0 with no flag.
- wr_en and rd_en in the same cycle are independent; both are serviced.
- A WIDTH-bit wr_data is not resized. data_all is sliced exactly as listed in Ports.

Optional Feature:
Macro: ARRAY_ADDR_SWAP_EN.
- When defined: wr_addr and rd_addr map to physical index DEPTH-1-addr. The range check still uses the raw addr >= DEPTH. load_all, rot_en and the out ordering are unchanged.
- When undefined: the index equals addr directly.

Test Plan (all with defaults: WIDTH=2, DEPTH=4, CNT_W=8):
- Reset, then load_all with data_all = 8'b00011011 -> next cycle out = 8'h1B and wr_count = 1. Then assert rst for one cycle -> out = 0, wr_count = 0, all pulse outputs = 0.
- Starting with all entries = 0: wr_en with wr_addr = 2, wr_data = 2'b11, and rd_en with rd_addr = 2 in the same cycle -> rd_data = 2'b00 with rd_valid = 1. A repeat read next cycle -> rd_data = 2'b11, and out = 8'b00001100.
- After the load of 8'h1B: rot_en for one cycle -> out = 8'b01101100. Three more rot_en cycles -> out = 8'h1B again, and wr_count is unchanged.
- rot_en and wr_en (addr 0, data 2'b10) in the same cycle -> the rotation is applied, wr_drop pulses once, and wr_count is unchanged.
- With DEPTH=3, ADDR_W=2: wr_en to addr 3 -> the array is unchanged and addr_err pulses. rd_en to addr 3 -> rd_data = 0 with rd_valid = 1 and addr_err = 1.
- With ARRAY_ADDR_SWAP_EN defined: wr_en to addr 0 with data 2'b01 from all-zero -> out = 8'b00000001. Also run 256 addressed writes -> wr_count wraps to 0.
